// File: rtl/sha256_w_mem_rollback_if.sv
// Request/response bundle for the SHA-256 message-schedule rollback engine.
// The master side issues a window plus step count; the slave side returns the rewound window.
interface sha256_w_mem_rollback_if;
  logic         start;
  logic [5:0]   steps;
  logic [511:0] block_in;
  logic         busy;
  logic         done;
  logic [511:0] block_out;

  modport master (
    output start, steps, block_in,
    input  busy, done, block_out
  );

  modport slave (
    input  start, steps, block_in,
    output busy, done, block_out
  );
endinterface

// File: rtl/sha256_w_mem_rollback.sv
// Rewinds a 16-word SHA-256 schedule window by N steps, one inverse step per clock.
// The window register is exported directly and is only guaranteed valid while done=1.
module sha256_w_mem_rollback (
  input  logic                      CLK,
  input  logic                      RST,
  sha256_w_mem_rollback_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state;
  logic [5:0]   cnt;
  logic [511:0] win;
  logic         busy_q;
  logic         done_q;

  logic [31:0]  x1, x9, x14, x16, r;
  logic [511:0] next_win;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // NOTE: combinational logic uses blocking '=' and assigns every output on every path, so no latch is inferred.
  always_comb begin
    x1       = win[511:480];
    x9       = win[255:224];
    x14      = win[95:64];
    x16      = win[31:0];
    r        = x16 - sig0(x1) - x9 - sig1(x14);
    next_win = {r, win[511:32]};
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  // NOTE: RST is synchronous: it is only observed on a rising CLK edge.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      cnt    <= '0;
      win    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            win    <= bus.block_in;
            cnt    <= bus.steps;
            busy_q <= 1'b1;
            state  <= (bus.steps != 6'd0) ? RUN : FIN;
          end
        end
        RUN: begin
          win <= next_win;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.block_out = win;

endmodule

// File: tb/tb_sha256_w_mem_rollback.sv
// Randomized bench for sha256_w_mem_rollback against a word-array model of the
// forward SHA-256 schedule step and its inverse.
module tb_sha256_w_mem_rollback;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sha256_w_mem_rollback_if bus ();

  sha256_w_mem_rollback dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] m_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] m_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // w[0] is the oldest word (bits 511:480), w[15] the newest.
  function automatic logic [511:0] m_fwd(input logic [511:0] b, input int n);
    logic [31:0] w [16];
    logic [31:0] nw;
    logic [511:0] o;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int s = 0; s < n; s++) begin
      nw = w[0] + m_s0(w[1]) + w[9] + m_s1(w[14]);
      for (int i = 0; i < 15; i++) w[i] = w[i+1];
      w[15] = nw;
    end
    for (int i = 0; i < 16; i++) o[511 - 32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [511:0] m_back(input logic [511:0] b, input int n);
    logic [31:0] w [16];
    logic [31:0] r;
    logic [511:0] o;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int s = 0; s < n; s++) begin
      r = w[15] - m_s0(w[0]) - w[8] - m_s1(w[13]);
      for (int i = 15; i > 0; i--) w[i] = w[i-1];
      w[0] = r;
    end
    for (int i = 0; i < 16; i++) o[511 - 32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Issues one request and waits for done; lat = cycles from accept to done, -1 on timeout.
  task automatic run_one(input logic [511:0] blk, input logic [5:0] n,
                         output logic [511:0] res, output int lat, output logic busy_ok);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.steps    = n;
    bus.block_in = blk;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.steps    = ~n;
    bus.block_in = ~blk;
    busy_ok = (bus.busy === 1'b1) && (bus.done === 1'b0);
    lat = -1;
    res = '0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        res = bus.block_out;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.steps    = 6'd5;
    bus.block_in = rand_block();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    n_tests++; if (bus.block_out !== 512'd0) begin n_fail++; $display("FAIL reset_block_out got=%h exp=0", bus.block_out); end
    bus.start = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abc();
    logic [511:0] blk, exp, res;
    int lat;
    logic ok;
    blk = {416'd0, 32'h0000_0018, 32'h6162_6380, 32'h000F_0000};
    exp = {32'h6162_6380, 448'd0, 32'h0000_0018};
    run_one(blk, 6'd2, res, lat, ok);
    n_tests++; if (lat != 2) begin n_fail++; $display("FAIL abc_latency got=%0d exp=2", lat); end
    n_tests++; if (res !== exp) begin n_fail++; $display("FAIL abc_result got=%h exp=%h", res, exp); end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL abc_busy got=bad exp=busy until done"); end
  endtask

  task automatic test_zero_steps();
    logic [511:0] blk, res;
    int lat;
    logic ok;
    blk = rand_block();
    run_one(blk, 6'd0, res, lat, ok);
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    n_tests++; if (res !== blk) begin n_fail++; $display("FAIL zero_result got=%h exp=%h", res, blk); end
    n_tests++; if (!ok) begin n_fail++; $display("FAIL zero_busy got=bad exp=one busy cycle"); end
    @(negedge clk);
    n_tests++; if (bus.block_out !== blk || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL zero_hold got=%h done=%b exp=%h done=0", bus.block_out, bus.done, blk);
    end
  endtask

  task automatic test_round_trip();
    logic [511:0] b, res;
    int lat, n;
    logic ok;
    b = rand_block();
    run_one(m_fwd(b, 48), 6'd48, res, lat, ok);
    n_tests++; if (lat != 48) begin n_fail++; $display("FAIL rt48_latency got=%0d exp=48", lat); end
    n_tests++; if (res !== b) begin n_fail++; $display("FAIL rt48_result got=%h exp=%h", res, b); end
    for (int i = 0; i < 200; i++) begin
      b = rand_block();
      n = $urandom_range(1, 63);
      run_one(m_fwd(b, n), n[5:0], res, lat, ok);
      n_tests++; if (lat != n) begin n_fail++; $display("FAIL rt_latency[%0d] got=%0d exp=%0d", i, lat, n); end
      n_tests++; if (res !== b) begin n_fail++; $display("FAIL rt_result[%0d] n=%0d got=%h exp=%h", i, n, res, b); end
      n_tests++; if (!ok) begin n_fail++; $display("FAIL rt_busy[%0d] got=bad exp=busy until done", i); end
    end
  endtask

  task automatic test_start_spam();
    logic [511:0] blk, exp, res;
    int dones, done_at;
    blk = rand_block();
    exp = m_back(blk, 10);
    @(negedge clk);
    bus.start = 1'b1; bus.steps = 6'd10; bus.block_in = blk;
    @(posedge clk);
    dones = 0; done_at = -1; res = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (done_at < 0) begin done_at = k; res = bus.block_out; end
      end
      if (done_at >= 0) bus.start = 1'b0;
      else begin bus.steps = 6'($urandom_range(0, 63)); bus.block_in = rand_block(); end
    end
    n_tests++; if (done_at != 10) begin n_fail++; $display("FAIL spam_latency got=%0d exp=10", done_at); end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL spam_done_count got=%0d exp=1", dones); end
    n_tests++; if (res !== exp) begin n_fail++; $display("FAIL spam_result got=%h exp=%h", res, exp); end
  endtask

  task automatic test_mid_reset();
    logic [511:0] blk, res;
    int lat, dones;
    logic ok;
    @(negedge clk);
    bus.start = 1'b1; bus.steps = 6'd20; bus.block_in = rand_block();
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b exp=0", bus.done); end
    n_tests++; if (bus.block_out !== 512'd0) begin n_fail++; $display("FAIL midrst_block_out got=%h exp=0", bus.block_out); end
    rst_n = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    blk = rand_block();
    run_one(blk, 6'd7, res, lat, ok);
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL midrst_fresh_latency got=%0d exp=7", lat); end
    n_tests++; if (res !== m_back(blk, 7)) begin n_fail++; $display("FAIL midrst_fresh_result got=%h exp=%h", res, m_back(blk, 7)); end
  endtask

  task automatic test_back_to_back();
    logic [511:0] drv [0:20];
    logic exp_done;
    // drv[e] is the block_in present at edge E0+e; accepts land on e = 0, 4, 8, 12.
    drv[0] = rand_block();
    @(negedge clk);
    bus.start = 1'b1; bus.steps = 6'd3; bus.block_in = drv[0];
    @(posedge clk);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      exp_done = (c % 4 == 3);
      n_tests++;
      if (bus.done !== exp_done) begin
        n_fail++; $display("FAIL b2b_done[%0d] got=%b exp=%b", c, bus.done, exp_done);
      end else if (exp_done) begin
        n_tests++;
        if (bus.block_out !== m_back(drv[c - 3], 3)) begin
          n_fail++; $display("FAIL b2b_result[%0d] got=%h exp=%h", c, bus.block_out, m_back(drv[c - 3], 3));
        end
      end
      drv[c + 1] = rand_block();
      bus.block_in = drv[c + 1];
      if (c == 15) bus.start = 1'b0;
    end
    repeat (6) @(negedge clk);
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", bus.busy); end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.steps    = '0;
    bus.block_in = '0;
    test_reset();
    test_abc();
    test_zero_steps();
    test_round_trip();
    test_start_spam();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
